// File: rtl/systolic_array_controller_pkg.sv
// systolic_ctrl_pkg: shared types and sizing helpers for the systolic array
// controller and its skew feeder.
//   state_t            - controller FSM states
//   FEED_CYCLES        - feed length for the default 3x3 array
//   feed_cycles()      - feed length (3N-2) for an arbitrary array size
//   feed_count_width() - width of the shared phase counter
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int MATRIX_SIZE_DEFAULT = 3;
  localparam int FEED_CYCLES = 3 * MATRIX_SIZE_DEFAULT - 2;

  // Skewed feeding of an NxN product needs 3N-2 cycles: the last operand pair
  // reaches PE(N-1,N-1) at t = (N-1) + (N-1) + (N-1).
  function automatic int feed_cycles(input int n);
    return 3 * n - 2;
  endfunction

  // The counter indexes FEED (up to 3N-3) and DRAIN (up to latency-1), so it
  // must be wide enough for whichever is larger.
  function automatic int feed_count_width(input int n, input int latency);
    int w;
    w = $clog2(3 * n);
    if ($clog2(latency + 1) > w) w = $clog2(latency + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/systolic_array_controller_skew_feeder.sv
// systolic_skew_feeder: turns the feed counter plus one NxN operand matrix
// into one skewed edge vector for the systolic array.
//   en       in  1        drive operands (FEED state); otherwise all zero
//   step     in  CW       feed step t
//   mat_flat in  DW*N*N   matrix, element [r][c] at (r*N+c)*DW
//   vec_flat out DW*N     slot s carries element k = t-s of lane s, or 0
// COL_MAJOR=0: slot s = row s, reads M[s][t-s]     (left edge, matrix A)
// COL_MAJOR=1: slot s = column s, reads M[t-s][s]  (top edge, matrix B)
module systolic_skew_feeder #(
  parameter int N         = 3,
  parameter int DW        = 8,
  parameter int CW        = 4,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic                en,
  input  logic [CW-1:0]       step,
  input  logic [DW*N*N-1:0]   mat_flat,
  output logic [DW*N-1:0]     vec_flat
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      logic [DW-1:0] slot;

      // Each slot is a small mux over its N candidate elements; k out of
      // range simply matches no candidate, which zero-fills the slot.
      always_comb begin
        slot = '0;
        for (int k = 0; k < N; k++) begin
          if (en && (int'(step) == gi + k)) begin
            slot = mat_flat[(COL_MAJOR ? (k * N + gi) : (gi * N + k)) * DW +: DW];
          end
        end
      end

      assign vec_flat[gi*DW +: DW] = slot;
    end
  endgenerate

endmodule

// File: rtl/systolic_array_controller.sv
// systolic_array_controller: sequencer for an NxN systolic multiply array.
// Captures A and B on start, clears the accumulators, feeds skewed A rows on
// the left edge and B columns on the top edge, waits PE_LATENCY cycles for
// the PE pipeline, then latches the accumulators into result_flat.
// Ports:
//   clk, rst (sync, active high), start
//   stall                      (only when SA_CTRL_STALL_EN is defined)
//   a_flat, b_flat             operand matrices, row-major
//   acc_out_flat               accumulators from the array
//   acc_rst, acc_en, shift_en  array control
//   in_left_flat, in_top_flat  skewed edge operands
//   busy, done, result_valid, result_flat
// Optional feature macro: SA_CTRL_STALL_EN (stall freezes FEED/DRAIN).
module systolic_array_controller
  import systolic_ctrl_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int PE_LATENCY  = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
`ifdef SA_CTRL_STALL_EN
  input  logic                                        stall,
`endif
  input  logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] a_flat,
  input  logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] b_flat,
  input  logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]  acc_out_flat,
  output logic                                        acc_rst,
  output logic                                        acc_en,
  output logic                                        shift_en,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0]           in_left_flat,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0]           in_top_flat,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        result_valid,
  output logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]  result_flat
);

  localparam int CW = feed_count_width(MATRIX_SIZE, PE_LATENCY);
  localparam logic [CW-1:0] FEED_LAST  = CW'(feed_cycles(MATRIX_SIZE) - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((PE_LATENCY > 0) ? (PE_LATENCY - 1) : 0);
  localparam int OPW = DATA_WIDTH * MATRIX_SIZE * MATRIX_SIZE;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          count_reg, count_next;
  logic [OPW-1:0]         a_reg, b_reg;
  logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] result_reg;
  logic                   hold;
  logic                   load;
  logic                   feeding;

`ifdef SA_CTRL_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // Operands are only ever sampled where start is honoured.
  assign load = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
          count_next = '0;
        end
      end
      CLEAR: begin
        state_next = FEED;
        count_next = '0;
      end
      FEED: begin
        if (!hold) begin
          if (count_reg == FEED_LAST) begin
            if (PE_LATENCY == 0) state_next = CAPTURE;
            else                 state_next = DRAIN;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (!hold) begin
          if (count_reg == DRAIN_LAST) begin
            state_next = CAPTURE;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      CAPTURE: begin
        state_next = DONE;
        count_next = '0;
      end
      DONE: begin
        if (start) begin
          state_next = CLEAR;
          count_next = '0;
        end else begin
          // Counter value 0 marks the first DONE cycle (the done pulse).
          count_next = CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (load) begin
        a_reg <= a_flat;
        b_reg <= b_flat;
      end
      if (state_reg == CAPTURE) begin
        result_reg <= acc_out_flat;
      end
    end
  end

  assign feeding = (state_reg == FEED);

  // While stalled the counter is frozen, so the edge vectors hold naturally.
  systolic_skew_feeder #(
    .N(MATRIX_SIZE), .DW(DATA_WIDTH), .CW(CW), .COL_MAJOR(1'b0)
  ) u_left_feeder (
    .en(feeding), .step(count_reg), .mat_flat(a_reg), .vec_flat(in_left_flat)
  );

  systolic_skew_feeder #(
    .N(MATRIX_SIZE), .DW(DATA_WIDTH), .CW(CW), .COL_MAJOR(1'b1)
  ) u_top_feeder (
    .en(feeding), .step(count_reg), .mat_flat(b_reg), .vec_flat(in_top_flat)
  );

  assign acc_rst      = (state_reg == CLEAR);
  assign acc_en       = feeding && !hold;
  assign shift_en     = feeding && !hold;
  assign busy         = (state_reg == CLEAR) || (state_reg == FEED) ||
                        (state_reg == DRAIN) || (state_reg == CAPTURE);
  assign done         = (state_reg == DONE) && (count_reg == '0);
  assign result_valid = (state_reg == DONE);
  assign result_flat  = result_reg;

endmodule
